// File: rtl/perturbation_stall_gen.sv
// perturbation_stall_gen
//   Sits between a core and a memory model. It delays per-channel grants by a
//   configurable number of cycles so that core timing corner cases are exercised.
//   Each channel has its own IDLE/DELAY/PASS FSM. Channels share the mode, delay
//   and LFSR inputs but otherwise do not interact.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   mode_i         1=STANDARD 2=RANDOM 3=PC_TRIG 4=SOFTWARE_DEFINED (other = STANDARD)
//   sw_delay_i     delay used by SOFTWARE_DEFINED and by PC_TRIG on a PC hit
//   pc_i           core PC, qualified by pc_valid_i, compared against pc_trig_i
//   req_i / gnt_i  per-channel request from the core / grant from the memory model
//   gnt_o          perturbed per-channel grant to the core
//   stall_cycles_o per-channel 32-bit stall counters; channel c at [32c+31:32c]
//
// Build option
//   PERTURB_STATS_EN  when defined, the saturating stall counters are present;
//                     otherwise stall_cycles_o is tied to zero.

module perturbation_stall_gen #(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned DELAY_W   = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [31:0]           mode_i,
   input  logic [DELAY_W-1:0]    sw_delay_i,
   input  logic [31:0]           pc_i,
   input  logic                  pc_valid_i,
   input  logic [31:0]           pc_trig_i,
   input  logic [NUM_CH-1:0]     req_i,
   input  logic [NUM_CH-1:0]     gnt_i,
   output logic [NUM_CH-1:0]     gnt_o,
   output logic [NUM_CH*32-1:0]  stall_cycles_o
);

   localparam logic [1:0]  StIdle   = 2'd0;
   localparam logic [1:0]  StDelay  = 2'd1;
   localparam logic [1:0]  StPass   = 2'd2;
   localparam logic [15:0] LfsrTaps = 16'hB400;

   logic w_mode_rand;
   logic w_mode_pc;
   logic w_mode_sw;
   logic w_pc_hit;

   assign w_mode_rand = (mode_i == 32'd2);
   assign w_mode_pc   = (mode_i == 32'd3);
   assign w_mode_sw   = (mode_i == 32'd4);
   assign w_pc_hit    = pc_valid_i && (pc_i == pc_trig_i);

   // Galois LFSR, free-running in every mode
   logic [15:0] r_lfsr;
   logic [15:0] w_lfsr_d;

   always_comb begin
      w_lfsr_d = r_lfsr >> 1;
      if (r_lfsr[0]) begin
         w_lfsr_d = w_lfsr_d ^ LfsrTaps;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lfsr <= LFSR_SEED;
      end else if (w_lfsr_d == 16'h0000) begin
         // Only reachable with a zero seed; keeps the sequence alive
         r_lfsr <= LFSR_SEED;
      end else begin
         r_lfsr <= w_lfsr_d;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam int unsigned Rot = (3 * c) % 16;

      logic [DELAY_W-1:0] w_rand_d;
      logic [DELAY_W-1:0] w_d;
      logic [DELAY_W-1:0] r_cnt;
      logic [DELAY_W-1:0] w_cnt_d;
      logic [1:0]         r_state;
      logic [1:0]         w_state_d;
      logic               w_gnt;

      // Low bits of the LFSR rotated left by 3*c: out[i] = lfsr[(i - Rot) mod 16]
      for (genvar i = 0; i < DELAY_W; i++) begin : g_rot
         assign w_rand_d[i] = r_lfsr[(i + 16 - Rot) % 16];
      end

      always_comb begin
         if (w_mode_rand) begin
            w_d = w_rand_d;
         end else if (w_mode_sw || (w_mode_pc && w_pc_hit)) begin
            w_d = sw_delay_i;
         end else begin
            w_d = '0;
         end
      end

      // Delay is only consumed in IDLE, so mode/delay changes mid-transaction are ignored
      always_comb begin
         w_state_d = r_state;
         w_cnt_d   = r_cnt;
         w_gnt     = 1'b0;
         case (r_state)
            StIdle: begin
               if (req_i[c]) begin
                  if (w_d == '0) begin
                     w_gnt = gnt_i[c];
                     if (!gnt_i[c]) begin
                        w_state_d = StPass;
                     end
                  end else begin
                     w_cnt_d   = w_d - DELAY_W'(1);
                     w_state_d = StDelay;
                  end
               end
            end
            StDelay: begin
               if (!req_i[c]) begin
                  w_state_d = StIdle;
                  w_cnt_d   = '0;
               end else if (r_cnt == '0) begin
                  w_state_d = StPass;
               end else begin
                  w_cnt_d = r_cnt - DELAY_W'(1);
               end
            end
            StPass: begin
               w_gnt = gnt_i[c] & req_i[c];
               if (!req_i[c] || gnt_i[c]) begin
                  w_state_d = StIdle;
               end
            end
            default: begin
               w_state_d = StIdle;
               w_cnt_d   = '0;
            end
         endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_state <= StIdle;
            r_cnt   <= '0;
         end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
         end
      end

      // Reset gating keeps the combinational IDLE pass-through quiet during reset
      assign gnt_o[c] = w_gnt & rst_ni;

`ifdef PERTURB_STATS_EN
      logic [31:0] r_stall;
      logic        w_stall_inc;

      assign w_stall_inc = (r_state == StDelay) ||
                           ((r_state == StPass) && req_i[c] && !w_gnt);

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_stall <= '0;
         end else if (w_stall_inc && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
         end
      end

      assign stall_cycles_o[32*c +: 32] = r_stall;
`else
      assign stall_cycles_o[32*c +: 32] = '0;
`endif
   end

endmodule

// File: tb/tb_perturbation_stall_gen.sv
// tb_perturbation_stall_gen
//   Directed bench for perturbation_stall_gen with the default parameters.
//   Inputs change on the falling edge and outputs are sampled 1 ns later.

module tb_perturbation_stall_gen;

   localparam logic [15:0] Seed = 16'hACE1;
   localparam logic [31:0] Trig = 32'h1C00_0080;
`ifdef PERTURB_STATS_EN
   localparam bit StatsOn = 1'b1;
`else
   localparam bit StatsOn = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] mode;
   logic [3:0]  sw_delay;
   logic [31:0] pc;
   logic        pc_valid;
   logic [31:0] pc_trig;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [1:0]  gnt_out;
   logic [63:0] stall;

   typedef struct {
      logic [31:0] mode;
      logic [3:0]  sw;
      logic        pv;
      logic [31:0] pc;
      logic [1:0]  req;
      logic [1:0]  gnt;
      logic [1:0]  exp;
   } vec_t;

   vec_t        tab[$];
   int          total;
   int          bad;
   int          ndiff;
   logic [15:0] m_lfsr;

   perturbation_stall_gen #(
      .NUM_CH    (2),
      .DELAY_W   (4),
      .LFSR_SEED (Seed)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .mode_i         (mode),
      .sw_delay_i     (sw_delay),
      .pc_i           (pc),
      .pc_valid_i     (pc_valid),
      .pc_trig_i      (pc_trig),
      .req_i          (req),
      .gnt_i          (gnt),
      .gnt_o          (gnt_out),
      .stall_cycles_o (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      logic [15:0] y;
      y = x >> 1;
      if (x[0]) y = y ^ 16'hB400;
      return y;
   endfunction

   function automatic logic [15:0] rotl(input logic [15:0] x, input int s);
      logic [31:0] t;
      t = {x, x} << s;
      return t[31:16];
   endfunction

   task automatic add(input logic [31:0] m, input logic [3:0] s, input logic v,
                      input logic [31:0] p, input logic [1:0] r, input logic [1:0] g,
                      input logic [1:0] e);
      vec_t x;
      x.mode = m; x.sw = s; x.pv = v; x.pc = p; x.req = r; x.gnt = g; x.exp = e;
      tab.push_back(x);
   endtask

   task automatic drive(input logic [31:0] m, input logic [3:0] s, input logic v,
                        input logic [31:0] p, input logic [1:0] r, input logic [1:0] g);
      mode = m; sw_delay = s; pc_valid = v; pc = p; req = r; gnt = g;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock: posedge (model LFSR follows the DUT), then back to the falling edge
   task automatic cyc();
      @(posedge clk);
      if (rst_n) m_lfsr = lfsr_step(m_lfsr);
      @(negedge clk);
   endtask

   initial begin
      total = 0; bad = 0; ndiff = 0;
      rst_n = 1'b0; m_lfsr = Seed; pc_trig = Trig;
      drive(32'd1, 4'd0, 1'b0, 32'd0, 2'b11, 2'b11);

      // Reset state: IDLE pass-through must be masked while in reset
      @(negedge clk);
      #1;
      chk("reset gnt_o", {62'd0, gnt_out}, 64'd0);
      chk("reset stall", stall, 64'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // mode, sw, pc_valid, pc, req, gnt, expected gnt_o
      for (int i = 0; i < 10; i++) add(1, 0, 0, 0, 2'b11, 2'b11, 2'b11);
      add(1, 0, 0, 0, 2'b01, 2'b00, 2'b00);    // ch0 -> PASS
      add(1, 0, 0, 0, 2'b01, 2'b01, 2'b01);    // PASS grant
      add(0, 0, 0, 0, 2'b10, 2'b10, 2'b10);    // mode 0 behaves as STANDARD
      add(5, 9, 0, 0, 2'b11, 2'b11, 2'b11);    // mode 5 behaves as STANDARD
      add(1, 0, 0, 0, 2'b00, 2'b11, 2'b00);    // no request, no grant
      add(4, 3, 0, 0, 2'b01, 2'b01, 2'b00);    // sw delay 3
      add(1, 0, 0, 0, 2'b01, 2'b01, 2'b00);    // mode change ignored mid-delay
      add(1, 0, 0, 0, 2'b01, 2'b01, 2'b00);
      add(2, 15, 0, 0, 2'b01, 2'b01, 2'b00);
      add(1, 0, 0, 0, 2'b01, 2'b01, 2'b01);    // grant on 4th cycle after request
      add(4, 2, 0, 0, 2'b11, 2'b11, 2'b00);    // both channels delay 2
      add(4, 2, 0, 0, 2'b11, 2'b11, 2'b00);
      add(4, 2, 0, 0, 2'b11, 2'b11, 2'b00);
      add(4, 2, 0, 0, 2'b11, 2'b01, 2'b01);    // ch1 held in PASS
      add(4, 2, 0, 0, 2'b10, 2'b10, 2'b10);
      add(3, 5, 1, Trig, 2'b01, 2'b01, 2'b00); // PC hit -> 5-cycle stall
      for (int i = 0; i < 5; i++) add(3, 5, 1, Trig + 4, 2'b01, 2'b01, 2'b00);
      add(3, 5, 1, Trig + 4, 2'b01, 2'b01, 2'b01);
      add(3, 5, 1, Trig + 4, 2'b01, 2'b01, 2'b01); // PC miss -> no stall
      add(3, 5, 0, Trig, 2'b01, 2'b01, 2'b01);     // PC not valid -> no stall
      add(3, 5, 1, Trig, 2'b10, 2'b10, 2'b00);     // ch1 hit
      add(1, 0, 0, 0, 2'b00, 2'b11, 2'b00);        // abort ch1 DELAY
      add(1, 0, 0, 0, 2'b10, 2'b10, 2'b10);        // ch1 back in IDLE
      add(4, 7, 0, 0, 2'b01, 2'b01, 2'b00);        // sw delay 7
      add(4, 7, 0, 0, 2'b01, 2'b01, 2'b00);
      add(4, 7, 0, 0, 2'b01, 2'b01, 2'b00);
      add(4, 7, 0, 0, 2'b00, 2'b01, 2'b00);        // drop req on stall cycle 3
      add(1, 0, 0, 0, 2'b01, 2'b01, 2'b01);        // ch0 IDLE again
      add(1, 0, 0, 0, 2'b01, 2'b00, 2'b00);        // -> PASS
      add(1, 0, 0, 0, 2'b00, 2'b01, 2'b00);        // abort PASS
      add(4, 1, 0, 0, 2'b01, 2'b01, 2'b00);        // delay 1 from IDLE
      add(4, 1, 0, 0, 2'b01, 2'b01, 2'b00);
      add(4, 1, 0, 0, 2'b01, 2'b01, 2'b01);

      foreach (tab[i]) begin
         drive(tab[i].mode, tab[i].sw, tab[i].pv, tab[i].pc, tab[i].req, tab[i].gnt);
         #1;
         chk($sformatf("vec%0d gnt_o", i), {62'd0, gnt_out}, {62'd0, tab[i].exp});
         cyc();
      end

      // Stall statistics from a clean reset
      rst_n = 1'b0; m_lfsr = Seed;
      drive(1, 0, 0, 0, 2'b00, 2'b00);
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(4, 3, 0, 0, 2'b01, 2'b01);
         cyc();
      end
      drive(1, 0, 0, 0, 2'b00, 2'b00);
      #1;
      chk("stats ch0 delay3", {32'd0, stall[31:0]}, StatsOn ? 64'd3 : 64'd0);
      chk("stats ch1 idle", {32'd0, stall[63:32]}, 64'd0);
      drive(1, 0, 0, 0, 2'b01, 2'b00); cyc();
      drive(1, 0, 0, 0, 2'b01, 2'b00); cyc();
      drive(1, 0, 0, 0, 2'b01, 2'b01); cyc();
      drive(1, 0, 0, 0, 2'b00, 2'b00);
      #1;
      chk("stats ch0 pass wait", {32'd0, stall[31:0]}, StatsOn ? 64'd4 : 64'd0);

      // Asynchronous reset in the middle of a delay
      for (int i = 0; i < 3; i++) begin
         drive(4, 7, 0, 0, 2'b01, 2'b01);
         cyc();
      end
      #1;
      chk("mid-delay gnt_o", {62'd0, gnt_out}, 64'd0);
      chk("mid-delay stats", {32'd0, stall[31:0]}, StatsOn ? 64'd6 : 64'd0);
      rst_n = 1'b0; m_lfsr = Seed;
      drive(1, 0, 0, 0, 2'b01, 2'b01);
      #1;
      chk("async reset gnt_o", {62'd0, gnt_out}, 64'd0);
      chk("async reset stall", stall, 64'd0);
      cyc();
      rst_n = 1'b1;
      #1;
      chk("after reset idle gnt", {62'd0, gnt_out}, 64'd1);
      cyc();

      // RANDOM mode: 500 rounds x 2 channels against the reference LFSR
      rst_n = 1'b0; m_lfsr = Seed;
      drive(2, 0, 0, 0, 2'b00, 2'b00);
      cyc();
      rst_n = 1'b1;
      for (int r = 0; r < 500; r++) begin
         int          t0, t1, o0, o1;
         logic        g0, g1;
         logic [15:0] rt;
         logic [1:0]  e;
         rt = rotl(m_lfsr, 0);
         t0 = (rt[3:0] == 4'd0) ? 0 : int'(rt[3:0]) + 1;
         rt = rotl(m_lfsr, 3);
         t1 = (rt[3:0] == 4'd0) ? 0 : int'(rt[3:0]) + 1;
         o0 = -1; o1 = -1; g0 = 1'b0; g1 = 1'b0;
         for (int k = 0; k < 20 && !(g0 && g1); k++) begin
            e = {(k == t1), (k == t0)};
            drive(2, 0, 0, 0, {~g1, ~g0}, 2'b11);
            #1;
            chk($sformatf("rand r%0d k%0d gnt_o", r, k), {62'd0, gnt_out}, {62'd0, e});
            if (gnt_out[0] && o0 < 0) o0 = k;
            if (gnt_out[1] && o1 < 0) o1 = k;
            if (k == t0) g0 = 1'b1;
            if (k == t1) g1 = 1'b1;
            cyc();
         end
         if (o0 != o1) ndiff++;
      end
      chk("rand channels differ", {63'd0, (ndiff != 0)}, 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/perturbation_stall_gen.md
PERTURBATION_STALL_GEN -- requirements
Module: perturbation_stall_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of independent request/grant channels (1..8).
REQ-002 SHALL have parameter DELAY_W, default 4, meaning width of delay values in cycles (1..16).
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning LFSR reset value (nonzero).
REQ-004 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port mode_i  input  32  mode: 1=STANDARD, 2=RANDOM, 3=PC_TRIG, 4=SOFTWARE_DEFINED; other values behave as STANDARD.
REQ-007 SHALL have port sw_delay_i  input  DELAY_W  delay for SOFTWARE_DEFINED and PC_TRIG.
REQ-008 SHALL have port pc_i  input  32  core PC; pc_valid_i  input  1  qualifies pc_i; pc_trig_i  input  32  trigger PC.
REQ-009 SHALL have port req_i  input  NUM_CH  per-channel request from core side.
REQ-010 SHALL have port gnt_i  input  NUM_CH  per-channel grant from memory model.
REQ-011 SHALL have port gnt_o  output  NUM_CH  perturbed grant to core.
REQ-012 SHALL have port stall_cycles_o  output  NUM_CH*32  per-channel stall counters, channel c at bits [32c+31:32c].

Function
REQ-013 Each channel SHALL run an independent FSM: IDLE, DELAY, PASS.
REQ-014 Delay value d SHALL be: STANDARD 0; RANDOM low DELAY_W bits of LFSR rotated left by 3*c for channel c; SOFTWARE_DEFINED sw_delay_i; PC_TRIG sw_delay_i if pc_valid_i and pc_i==pc_trig_i in that cycle, else 0.
REQ-015 IDLE with req_i[c]=1 and d=0: gnt_o[c]=gnt_i[c] same cycle; stay IDLE if gnt_o[c]=1, else go PASS.
REQ-016 IDLE with req_i[c]=1 and d>0: gnt_o[c]=0; load counter with d-1; go DELAY.
REQ-017 DELAY: gnt_o[c]=0; counter decrements each cycle; at counter 0 go PASS next cycle (total d stall cycles before PASS).
REQ-018 PASS: gnt_o[c]=gnt_i[c]&req_i[c]; on gnt_o[c]=1 go IDLE.
REQ-019 req_i[c] deasserted in DELAY or PASS SHALL abort to IDLE next cycle with gnt_o[c]=0 that cycle.
REQ-020 gnt_o[c] SHALL be 0 whenever req_i[c]=0.
REQ-021 d and mode SHALL be sampled only on the IDLE->DELAY/PASS transition; mode_i/sw_delay_i changes mid-transaction SHALL NOT affect the running count.
REQ-022 LFSR SHALL be 16-bit Galois, taps 16'hB400, shifting every cycle regardless of mode; never all-zero.
REQ-023 Channels SHALL not interact; simultaneous requests on all channels SHALL be handled in parallel.

Reset
REQ-024 While rst_ni=0: all FSMs IDLE, counters 0, LFSR=LFSR_SEED, gnt_o=0, stall_cycles_o=0.
REQ-025 Reset assertion mid-DELAY SHALL abort immediately (asynchronous); first request after release restarts from IDLE.

Configuration
REQ-026 Macro PERTURB_STATS_EN: defined -> stall_cycles_o[c] increments by 1 each cycle channel c is in DELAY, or in PASS with req_i[c]=1 and gnt_o[c]=0, saturating at 32'hFFFF_FFFF.
REQ-027 PERTURB_STATS_EN undefined -> counters absent, stall_cycles_o tied to 0; all other behaviour identical.

Verification
REQ-028 mode_i=1, req_i=2'b11, gnt_i=2'b11 -> gnt_o=2'b11 same cycle, zero stall, 10 back-to-back transactions in 10 cycles.
REQ-029 mode_i=4, sw_delay_i=3, req_i[0] held, gnt_i[0]=1 -> gnt_o[0] first high on cycle 4 after request; stall_cycles_o[31:0]=3 with PERTURB_STATS_EN.
REQ-030 mode_i=3, pc_trig_i=32'h1C00_0080, sw_delay_i=5; request with pc_i=32'h1C00_0080 -> 5-cycle stall; with pc_i=32'h1C00_0084 -> zero stall.
REQ-031 mode_i=2, LFSR_SEED=16'hACE1, 1000 requests -> per-cycle delays match reference LFSR model per channel; channels 0 and 1 delays differ.
REQ-032 mode_i=4, sw_delay_i=7; drop req_i[0] on stall cycle 3 -> gnt_o[0]=0, FSM IDLE next cycle; assert rst_ni=0 mid-DELAY -> gnt_o=0 immediately, stall_cycles_o=0.
